// File: rtl/instr_encoder.sv
// instr_encoder: takes decoded MIPS instruction fields over a valid/ready
// handshake, encodes each one into a 32-bit machine word, buffers the words in
// a small FIFO and writes them to instruction memory at consecutive word
// addresses. It is used to fill IM before the CPU is released.
//
// Optional feature macro: ENC_DELAY_SLOT_EN. When it is defined, every accepted
// jr/beq/j/jal is followed by a nop (32'h0) in the FIFO, filling the delay slot.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high (in_valid/in_ready for fields, im_we/im_ready for IM writes). Ready
// never depends on valid, and valid holds its payload stable until the transfer.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_sel,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic [PTR_W-1:0]    used;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                empty, full, room;
  logic                sel_ok, accept, push, push_nop, pop;
  logic                session_init, drained;
  logic [31:0]         enc_word;

  assign used   = wr_q - rd_q;
  assign wr_idx = wr_q[IDX_W-1:0];
  assign rd_idx = rd_q[IDX_W-1:0];
  assign empty  = (used == '0);
  assign full   = (used == PTR_W'(DEPTH));

`ifdef ENC_DELAY_SLOT_EN
  logic is_branch;
  // Control transfers get a nop behind them, so two free slots are needed.
  assign is_branch = (in_sel == 4'd2) || (in_sel == 4'd6) ||
                     (in_sel == 4'd8) || (in_sel == 4'd9);
  assign room      = ((PTR_W'(DEPTH) - used) >= PTR_W'(2));
  assign push_nop  = push && is_branch;
`else
  assign room      = !full;
  assign push_nop  = 1'b0;
`endif

  assign in_ready     = (state_q == S_LOAD) && room;
  assign accept       = in_valid && in_ready;
  assign push         = accept && sel_ok;
  assign busy         = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign im_we        = busy && !empty;
  assign pop          = im_we && im_ready;
  assign session_init = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  // The FIFO is empty after this edge: no pushes happen outside LOAD.
  assign drained      = empty || ((used == PTR_W'(1)) && pop);

  assign im_addr   = addr_q;
  assign im_wdata  = empty ? 32'h0 : mem_q[rd_idx];
  assign count     = count_q;
  assign err       = err_q;
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // Combinational encoder: field layout per opcode; unused fields are ignored.
  always_comb begin
    sel_ok   = 1'b1;
    enc_word = 32'h0;
    case (in_sel)
      4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      4'd2:    enc_word = {6'h00, in_rs, 15'd0, 6'h08};
      4'd3:    enc_word = {6'h0D, in_rs, in_rt, in_imm};
      4'd4:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      4'd5:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'h04, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'h0F, 5'd0, in_rt, in_imm};
      4'd8:    enc_word = {6'h02, in_target};
      4'd9:    enc_word = {6'h03, in_target};
      default: sel_ok   = 1'b0;
    endcase
  end

  // Session FSM next state: start opens a session, finish drains it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (finish) state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, address, counter and sticky-error updates.
  always_comb begin
    wr_d    = wr_q + PTR_W'(push) + PTR_W'(push_nop);
    rd_d    = rd_q + PTR_W'(pop);
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (session_init) begin
      addr_d  = ADDR_W'(BASE_ADDR);
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (pop) begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
        if (addr_q == '1) err_d = 1'b1;
      end
      if (accept && !sel_ok) err_d = 1'b1;
    end
  end

  // State and control registers; reset discards any buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // FIFO storage: encoded word at the tail, plus the delay-slot nop if any.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= enc_word;
    if (push_nop) mem_q[wr_idx + IDX_W'(1)] <= 32'h0;
  end

endmodule
